// File: rtl/memtest_sequencer.sv
// Write-then-verify memory test sequencer driving a save/restore/next vector generator and one memory port.
// Optional build macro MEMTEST_HALT_ON_ERR_EN: abort to IDLE on the first read mismatch.
module memtest_sequencer #(
    parameter int ADDR_W = 24,
    parameter int ERR_W  = 32,
    parameter int PASS_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              busy,
    output logic              rnd_save,
    output logic              rnd_restore,
    output logic              rnd_next,
    input  logic [15:0]       rnd_vec,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic [PASS_W-1:0] pass_cnt,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              err_flag,
    output logic [ADDR_W-1:0] last_err_addr
);

    // state     | meaning
    // IDLE      | waiting for start
    // SAVE      | snapshot generator state
    // WR        | write request held until ack
    // WR_STEP   | advance generator, next write address
    // RESTORE   | rewind generator to the snapshot
    // RD        | read request held until ack, compare
    // RD_STEP   | advance generator, next read address
    // PASS_END  | count pass, repeat or stop
    typedef enum logic [2:0] {
        S_IDLE, S_SAVE, S_WR, S_WR_STEP, S_RESTORE, S_RD, S_RD_STEP, S_PASS_END
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] last_q;
    logic              stop_q;
    logic              at_last;
    logic              mismatch;

    assign at_last   = (addr == last_q);
    assign mismatch  = mem_ack && (mem_rdata != rnd_vec);
    assign mem_addr  = addr;
    assign mem_wdata = rnd_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (start) state_nxt = S_SAVE;
            S_SAVE:     state_nxt = S_WR;
            S_WR:       if (mem_ack) state_nxt = S_WR_STEP;
            S_WR_STEP:  state_nxt = at_last ? S_RESTORE : S_WR;
            S_RESTORE:  state_nxt = S_RD;
            S_RD: begin
                if (mem_ack) begin
`ifdef MEMTEST_HALT_ON_ERR_EN
                    state_nxt = mismatch ? S_IDLE : S_RD_STEP;
`else
                    state_nxt = S_RD_STEP;
`endif
                end
            end
            S_RD_STEP:  state_nxt = at_last ? S_PASS_END : S_RD;
            S_PASS_END: state_nxt = stop_q ? S_IDLE : S_SAVE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != S_IDLE);
        rnd_save    = (state == S_SAVE);
        rnd_restore = (state == S_RESTORE);
        rnd_next    = (state == S_WR_STEP) || (state == S_RD_STEP);
        mem_req     = (state == S_WR) || (state == S_RD);
        mem_we      = (state == S_WR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr          <= '0;
            last_q        <= '0;
            stop_q        <= 1'b0;
            pass_cnt      <= '0;
            err_cnt       <= '0;
            err_flag      <= 1'b0;
            last_err_addr <= '0;
        end else begin
            if (state == S_IDLE) begin
                if (start) begin
                    // a stop arriving with start is kept so exactly one pass runs
                    stop_q        <= stop;
                    last_q        <= last_addr;
                    pass_cnt      <= '0;
                    err_cnt       <= '0;
                    err_flag      <= 1'b0;
                    last_err_addr <= '0;
                end
            end else if (stop) begin
                stop_q <= 1'b1;
            end

            case (state)
                S_SAVE, S_RESTORE: addr <= '0;
                S_WR_STEP, S_RD_STEP: if (!at_last) addr <= addr + 1'b1;
                default: ;
            endcase

            if (state == S_RD && mismatch) begin
                if (!(&err_cnt)) err_cnt <= err_cnt + 1'b1;
                err_flag      <= 1'b1;
                last_err_addr <= addr;
            end

            if (state == S_PASS_END) pass_cnt <= pass_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_memtest_sequencer.sv
// Bench for memtest_sequencer: behavioural generator/memory environment plus sequence-index reference model.
module tb_memtest_sequencer;
    localparam int ADDR_W = 24;
    localparam int ERR_W  = 32;
    localparam int PASS_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic              busy, rnd_save, rnd_restore, rnd_next;
    logic [15:0]       gen = 16'h1;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_ack = 1'b0;
    logic [15:0]       mem_rdata = '0;
    logic [PASS_W-1:0] pass_cnt;
    logic [ERR_W-1:0]  err_cnt;
    logic              err_flag;
    logic [ADDR_W-1:0] last_err_addr;

    memtest_sequencer #(.ADDR_W(ADDR_W), .ERR_W(ERR_W), .PASS_W(PASS_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .last_addr(last_addr),
        .busy(busy), .rnd_save(rnd_save), .rnd_restore(rnd_restore), .rnd_next(rnd_next),
        .rnd_vec(gen), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .pass_cnt(pass_cnt), .err_cnt(err_cnt), .err_flag(err_flag),
        .last_err_addr(last_err_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // environment state
    logic [15:0]       mem [16];
    logic [15:0]       inj [16];
    logic [15:0]       gen_saved = 16'h1;
    logic [15:0]       seed;
    logic [ADDR_W-1:0] wr_addr_q[$], rd_addr_q[$];
    logic [15:0]       wr_data_q[$];
    int n_save, n_restore, n_next;
    int lat_lo = 0, lat_hi = 0, lat = 0, wcnt = 0;
    logic hold_ack = 1'b0;

    function automatic logic [15:0] lfsr(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    // value of the generator after idx advances from seed
    function automatic logic [15:0] vec_at(input logic [15:0] s, input int idx);
        logic [15:0] v = s;
        for (int k = 0; k < idx; k++) v = lfsr(v);
        return v;
    endfunction

    // memory responder and vector generator, both acting on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mem_ack = 1'b0;
                wcnt = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
                wcnt = 0;
                lat = $urandom_range(lat_hi, lat_lo);
            end else if (mem_req && !hold_ack) begin
                if (wcnt >= lat) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        mem[mem_addr[3:0]] = mem_wdata;
                        wr_addr_q.push_back(mem_addr);
                        wr_data_q.push_back(mem_wdata);
                    end else begin
                        mem_rdata = mem[mem_addr[3:0]] ^ inj[mem_addr[3:0]];
                        rd_addr_q.push_back(mem_addr);
                    end
                end else begin
                    wcnt++;
                end
            end
            if (rst_n) begin
                if (rnd_save)    begin n_save++;    gen_saved = gen; end
                if (rnd_restore) begin n_restore++; gen = gen_saved; end
                if (rnd_next)    begin n_next++;    gen = lfsr(gen); end
            end
        end
    end

    task automatic prepare(input int lo, input int hi);
        @(negedge clk);
        seed = 16'($urandom_range(1, 16'hFFFF));
        gen = seed;
        wr_addr_q.delete(); rd_addr_q.delete(); wr_data_q.delete();
        n_save = 0; n_restore = 0; n_next = 0;
        for (int i = 0; i < 16; i++) begin inj[i] = '0; mem[i] = '0; end
        lat_lo = lo; lat_hi = hi; lat = lo;
    endtask

    task automatic do_start(input int la, input logic s);
        start = 1'b1; stop = s; last_addr = ADDR_W'(la);
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        last_addr = ADDR_W'($urandom_range(0, 15));
    endtask

    task automatic wait_idle(input int max_cyc, input string name);
        int n = 0;
        while (busy && n < max_cyc) begin @(negedge clk); n++; end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s timeout: busy=%b after %0d cycles, required 0", name, busy, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({busy, mem_req, mem_we, rnd_save, rnd_restore, rnd_next, err_flag} !== 7'b0 ||
            pass_cnt !== '0 || err_cnt !== '0 || last_err_addr !== '0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b req=%b pass=%0d err=%0d addr=%0h, required all 0",
                     busy, mem_req, pass_cnt, err_cnt, mem_addr);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_single_pass();
        prepare(2, 2);
        do_start(3, 1'b1);
        wait_idle(200, "single_pass");
        checks++;
        if (n_save !== 1 || n_restore !== 1 || n_next !== 8) begin
            errors++;
            $display("FAIL single_strobes: save=%0d restore=%0d next=%0d, required 1 1 8",
                     n_save, n_restore, n_next);
        end
        checks++;
        if (wr_addr_q.size() !== 4 || rd_addr_q.size() !== 4) begin
            errors++;
            $display("FAIL single_counts: writes=%0d reads=%0d, required 4 4",
                     wr_addr_q.size(), rd_addr_q.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (wr_addr_q[j] !== ADDR_W'(j) || wr_data_q[j] !== vec_at(seed, j) ||
                    rd_addr_q[j] !== ADDR_W'(j)) begin
                    errors++;
                    $display("FAIL single_word%0d: waddr=%0h wdata=%h raddr=%0h, required %0h %h %0h",
                             j, wr_addr_q[j], wr_data_q[j], rd_addr_q[j], j, vec_at(seed, j), j);
                end
            end
        end
        checks++;
        if (err_cnt !== '0 || err_flag !== 1'b0 || pass_cnt !== PASS_W'(1)) begin
            errors++;
            $display("FAIL single_result: err=%0d flag=%b pass=%0d, required 0 0 1",
                     err_cnt, err_flag, pass_cnt);
        end
    endtask

    // one pass with a bench-chosen corruption mask; expectations from the mask alone
    task automatic run_err_pass(input int la, input string name);
        int exp_err = 0, exp_last = 0, exp_pass = 1, exp_reads = la + 1;
        for (int a = 0; a <= la; a++) begin
            if (inj[a] != 0) begin
`ifdef MEMTEST_HALT_ON_ERR_EN
                if (exp_err == 0) begin
                    exp_err = 1; exp_last = a; exp_pass = 0; exp_reads = a + 1;
                end
`else
                exp_err++; exp_last = a;
`endif
            end
        end
        do_start(la, 1'b1);
        wait_idle(600, name);
        checks++;
        if (err_cnt !== ERR_W'(exp_err) || err_flag !== (exp_err != 0) ||
            pass_cnt !== PASS_W'(exp_pass) || last_err_addr !== ADDR_W'(exp_last)) begin
            errors++;
            $display("FAIL %s result: err=%0d flag=%b pass=%0d last=%0d, required %0d %b %0d %0d",
                     name, err_cnt, err_flag, pass_cnt, last_err_addr,
                     exp_err, exp_err != 0, exp_pass, exp_last);
        end
        checks++;
        if (wr_addr_q.size() !== la + 1 || rd_addr_q.size() !== exp_reads) begin
            errors++;
            $display("FAIL %s counts: writes=%0d reads=%0d, required %0d %0d",
                     name, wr_addr_q.size(), rd_addr_q.size(), la + 1, exp_reads);
        end
    endtask

    task automatic test_error_inject();
        prepare(0, 3);
        inj[2] = 16'h0001; inj[5] = 16'h0001;
        run_err_pass(7, "error_inject");
    endtask

    task automatic test_random_passes();
        for (int t = 0; t < 5; t++) begin
            int la = (t == 0) ? 0 : $urandom_range(1, 15);
            prepare(0, 3);
            for (int a = 0; a <= la; a++)
                if ($urandom_range(0, 3) == 0) inj[a] = 16'(1 << $urandom_range(0, 15));
            run_err_pass(la, $sformatf("random_pass%0d", t));
            for (int j = 0; j < wr_data_q.size(); j++) begin
                if (wr_data_q[j] !== vec_at(seed, j)) begin
                    checks++; errors++;
                    $display("FAIL random_pass%0d wdata%0d: %h, required %h",
                             t, j, wr_data_q[j], vec_at(seed, j));
                end
            end
        end
    endtask

    task automatic test_continuous();
        int n = 0;
        logic differ = 1'b0;
        prepare(0, 2);
        stop = 1'b1; @(negedge clk); stop = 1'b0;
        do_start(15, 1'b0);
        while (rd_addr_q.size() < 2 * 16 + 3 && n < 2000) begin @(negedge clk); n++; end
        stop = 1'b1; @(negedge clk); stop = 1'b0;
        wait_idle(600, "continuous");
        checks++;
        if (pass_cnt !== PASS_W'(3) || err_cnt !== '0) begin
            errors++;
            $display("FAIL continuous_result: pass=%0d err=%0d, required 3 0", pass_cnt, err_cnt);
        end
        checks++;
        if (wr_data_q.size() !== 48 || rd_addr_q.size() !== 48) begin
            errors++;
            $display("FAIL continuous_counts: writes=%0d reads=%0d, required 48 48",
                     wr_data_q.size(), rd_addr_q.size());
        end else begin
            for (int j = 0; j < 48; j++) begin
                checks++;
                if (wr_data_q[j] !== vec_at(seed, j) || wr_addr_q[j] !== ADDR_W'(j % 16)) begin
                    errors++;
                    $display("FAIL continuous_word%0d: addr=%0h data=%h, required %0h %h",
                             j, wr_addr_q[j], wr_data_q[j], j % 16, vec_at(seed, j));
                end
                if (j < 16 && wr_data_q[j + 16] != wr_data_q[j]) differ = 1'b1;
            end
            checks++;
            if (!differ) begin
                errors++;
                $display("FAIL continuous_new_data: pass2 data equals pass1, required different");
            end
        end
    endtask

    task automatic test_ack_stall();
        logic [ADDR_W-1:0] a0;
        logic [15:0]       d0;
        int n = 0;
        prepare(1, 1);
        hold_ack = 1'b1;
        do_start(3, 1'b1);
        while (!(mem_req && mem_we) && n < 20) begin @(negedge clk); n++; end
        a0 = mem_addr; d0 = mem_wdata;
        for (int c = 0; c < 10; c++) begin
            if (c == 4) begin start = 1'b1; last_addr = ADDR_W'(9); end
            if (c == 5) start = 1'b0;
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== a0 ||
                mem_wdata !== d0 || rnd_next !== 1'b0) begin
                errors++;
                $display("FAIL stall_cycle%0d: req=%b we=%b addr=%0h data=%h next=%b, required 1 1 %0h %h 0",
                         c, mem_req, mem_we, mem_addr, mem_wdata, rnd_next, a0, d0);
            end
        end
        hold_ack = 1'b0;
        wait_idle(200, "stall");
        checks++;
        if (wr_addr_q.size() !== 4 || pass_cnt !== PASS_W'(1) || n_save !== 1 ||
            wr_data_q[0] !== seed) begin
            errors++;
            $display("FAIL stall_result: writes=%0d pass=%0d saves=%0d, required 4 1 1",
                     wr_addr_q.size(), pass_cnt, n_save);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        prepare(0, 2);
        inj[0] = 16'h8000;
        do_start(15, 1'b0);
        while (!(rd_addr_q.size() >= 20 && mem_req && !mem_we) && n < 2000) begin
            @(negedge clk); n++;
        end
        checks++;
        if (pass_cnt === '0 || err_cnt === '0) begin
            errors++;
            $display("FAIL reset_mid_precondition: pass=%0d err=%0d, required nonzero", pass_cnt, err_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || pass_cnt !== '0 || err_cnt !== '0 ||
            err_flag !== 1'b0 || last_err_addr !== '0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: req=%b busy=%b pass=%0d err=%0d flag=%b, required all 0",
                     mem_req, busy, pass_cnt, err_cnt, err_flag);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle: busy=%b req=%b, required 0 0", busy, mem_req);
        end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_error_inject();
        test_random_passes();
        test_continuous();
        test_ack_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
